bc_control_unit: RTL and testbench

//  Hardwired control unit for the 16-bit basic computer. A sequence counter (SC) steps timing states T0..T6.
//  SC, IR, the I flag and datapath status decode into per-register write/increment/reset strobes, a bus source select, an ALU op and memory strobes.

---
 rtl/bc_pkg.sv | 21 ++
 rtl/bc_register.sv | 16 +
 rtl/bc_control_unit.sv | 107 ++++++++++
 tb/tb_bc_control_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// bc_pkg: shared opcode, bus-select and ALU-op encodings for the basic computer control unit.
package bc_pkg;
    localparam int SC_W = 4;
    localparam logic [SC_W-1:0] SC_MAX = 4'd6;
    typedef enum logic [2:0] {OP_AND, OP_ADD, OP_LDA, OP_STA, OP_BUN, OP_BSA, OP_ISZ, OP_REG} opcode_t;
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;
    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_LDDR = 3'd2;
    localparam logic [2:0] ALU_CMA  = 3'd3;
    localparam logic [2:0] ALU_SHR  = 3'd4;
    localparam logic [2:0] ALU_SHL  = 3'd5;
    localparam logic [2:0] ALU_INC  = 3'd6;
endpackage

// File: rtl/bc_register.sv
// bc_register: generic register with synchronous clear, parallel load and increment.
module bc_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic             increment,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk)
        if (reset) q <= '0;
        else if (write) q <= d;
        else if (increment) q <= q + 1'b1;
endmodule

// File: rtl/bc_control_unit.sv
// bc_control_unit: hardwired timing/decode control for the 16-bit basic computer.
module bc_control_unit
    import bc_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ir,
    input  logic              ac_zero,
    input  logic              ac_sign,
    input  logic              dr_zero,
    input  logic              e_flag,
    output logic              ar_write, ar_inc, ar_clr,
    output logic              pc_write, pc_inc, pc_clr,
    output logic              dr_write, dr_inc, dr_clr,
    output logic              ac_write, ac_inc, ac_clr,
    output logic              ir_write, ir_inc, ir_clr,
    output logic              tr_write, tr_inc, tr_clr,
    output logic [2:0]        bus_sel,
    output logic [2:0]        alu_op,
    output logic              e_clr, e_cmp,
    output logic              mem_read, mem_write,
    output logic              halted,
    output logic [SC_W-1:0]   sc
);
    logic i_flag, halt, sc_last, sc_clr, hlt, active;
    logic [7:0] d;
    logic [6:0] t;
    logic [ADDR_W-1:0] rr;

    bc_register #(.WIDTH(SC_W)) u_sc (
        .clk(clk), .reset(reset | sc_clr), .write(1'b0), .increment(!halt), .d('0), .q(sc)
    );

    assign d = 8'b1 << ir[DATA_W-2 -: 3];
    assign t = (sc <= SC_MAX) ? 7'(7'b1 << sc) : '0;
    assign rr = ir[ADDR_W-1:0];
    assign active = !reset && !halt;
    assign sc_clr = sc_last || (sc > SC_MAX);
    assign halted = halt;

    always_ff @(posedge clk)
        if (reset) begin
            i_flag <= 1'b0;
            halt <= 1'b0;
        end else if (!halt) begin
            if (t[2]) i_flag <= ir[DATA_W-1];
            if (hlt) halt <= 1'b1;
        end

    always_comb begin
        {ar_write, ar_inc, ar_clr, pc_write, pc_inc, pc_clr} = '0;
        {dr_write, dr_inc, dr_clr, ac_write, ac_inc, ac_clr} = '0;
        {ir_write, ir_inc, ir_clr, tr_write, tr_inc, tr_clr} = '0;
        {e_clr, e_cmp, mem_read, mem_write, sc_last, hlt} = '0;
        bus_sel = BUS_NONE;
        alu_op = ALU_AND;
        if (active) begin
            if (t[0]) begin bus_sel = BUS_PC; ar_write = 1'b1; end
            if (t[1]) begin bus_sel = BUS_MEM; mem_read = 1'b1; ir_write = 1'b1; pc_inc = 1'b1; end
            if (t[2]) begin bus_sel = BUS_IR; ar_write = 1'b1; end
            if (t[3] && d[OP_REG]) begin
                sc_last = 1'b1;
                // Register-reference: only the most significant set bit is honoured.
                if (!i_flag) begin
                    if (rr[11]) ac_clr = 1'b1;
                    else if (rr[10]) e_clr = 1'b1;
                    else if (rr[9]) begin alu_op = ALU_CMA; ac_write = 1'b1; end
                    else if (rr[8]) e_cmp = 1'b1;
                    else if (rr[7]) begin alu_op = ALU_SHR; ac_write = 1'b1; end
                    else if (rr[6]) begin alu_op = ALU_SHL; ac_write = 1'b1; end
                    else if (rr[5]) ac_inc = 1'b1;
                    else if (rr[4]) pc_inc = !ac_sign && !ac_zero;
                    else if (rr[3]) pc_inc = ac_sign;
                    else if (rr[2]) pc_inc = ac_zero;
                    else if (rr[1]) pc_inc = !e_flag;
                    else if (rr[0]) hlt = 1'b1;
                end
            end
            if (t[3] && !d[OP_REG] && i_flag) begin bus_sel = BUS_MEM; mem_read = 1'b1; ar_write = 1'b1; end
            if (t[4]) begin
                if (d[OP_AND] || d[OP_ADD] || d[OP_LDA] || d[OP_ISZ]) begin
                    bus_sel = BUS_MEM; mem_read = 1'b1; dr_write = 1'b1;
                end
                if (d[OP_STA]) begin bus_sel = BUS_AC; mem_write = 1'b1; sc_last = 1'b1; end
                if (d[OP_BUN]) begin bus_sel = BUS_AR; pc_write = 1'b1; sc_last = 1'b1; end
                if (d[OP_BSA]) begin bus_sel = BUS_PC; mem_write = 1'b1; ar_inc = 1'b1; end
            end
            if (t[5]) begin
                if (d[OP_AND] || d[OP_ADD] || d[OP_LDA]) begin
                    alu_op = d[OP_AND] ? ALU_AND : d[OP_ADD] ? ALU_ADD : ALU_LDDR;
                    ac_write = 1'b1;
                    sc_last = 1'b1;
                end
                if (d[OP_BSA]) begin bus_sel = BUS_AR; pc_write = 1'b1; sc_last = 1'b1; end
                if (d[OP_ISZ]) dr_inc = 1'b1;
            end
            if (t[6] && d[OP_ISZ]) begin
                bus_sel = BUS_DR; mem_write = 1'b1; pc_inc = dr_zero; sc_last = 1'b1;
            end
        end
    end

    sc_legal: assert property (@(posedge clk) disable iff (reset) sc <= SC_MAX);
endmodule

// File: tb/tb_bc_control_unit.sv
// tb_bc_control_unit: datapath + 4K x 16 memory model around the control unit, directed instruction checks.
module tb_bc_control_unit;
    logic clk = 1'b0, reset = 1'b1;
    logic [11:0] ar, pc;
    logic [15:0] dr, ac, ir_q, tr;
    logic e;
    logic [15:0] mem [0:4095];
    logic ar_write, ar_inc, ar_clr, pc_write, pc_inc, pc_clr, dr_write, dr_inc, dr_clr;
    logic ac_write, ac_inc, ac_clr, ir_write, ir_inc, ir_clr, tr_write, tr_inc, tr_clr;
    logic [2:0] bus_sel, alu_op;
    logic e_clr, e_cmp, mem_read, mem_write, halted, any_strobe;
    logic [3:0] sc;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    bc_control_unit dut (
        .clk(clk), .reset(reset), .ir(ir_q), .ac_zero(ac == 16'h0), .ac_sign(ac[15]),
        .dr_zero(dr == 16'h0), .e_flag(e),
        .ar_write(ar_write), .ar_inc(ar_inc), .ar_clr(ar_clr),
        .pc_write(pc_write), .pc_inc(pc_inc), .pc_clr(pc_clr),
        .dr_write(dr_write), .dr_inc(dr_inc), .dr_clr(dr_clr),
        .ac_write(ac_write), .ac_inc(ac_inc), .ac_clr(ac_clr),
        .ir_write(ir_write), .ir_inc(ir_inc), .ir_clr(ir_clr),
        .tr_write(tr_write), .tr_inc(tr_inc), .tr_clr(tr_clr),
        .bus_sel(bus_sel), .alu_op(alu_op), .e_clr(e_clr), .e_cmp(e_cmp),
        .mem_read(mem_read), .mem_write(mem_write), .halted(halted), .sc(sc)
    );

    assign any_strobe = |{ar_write, ar_inc, ar_clr, pc_write, pc_inc, pc_clr, dr_write, dr_inc, dr_clr,
                          ac_write, ac_inc, ac_clr, ir_write, ir_inc, ir_clr, tr_write, tr_inc, tr_clr,
                          e_clr, e_cmp, mem_read, mem_write} || bus_sel != 3'd0 || alu_op != 3'd0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expd);
        end
    endtask

    // Each cycle: latch strobes and bus at negedge, apply them to the datapath just after posedge.
    task automatic tick(input int n);
        logic [15:0] b, r, wd;
        logic cy, we;
        logic [11:0] n_ar, n_pc, wa;
        logic [15:0] n_dr, n_ac, n_ir, n_tr;
        logic n_e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            case (bus_sel)
                3'd1: b = {4'h0, ar};
                3'd2: b = {4'h0, pc};
                3'd3: b = dr;
                3'd4: b = ac;
                3'd5: b = ir_q;
                3'd6: b = tr;
                3'd7: b = mem[ar];
                default: b = 16'h0;
            endcase
            cy = 1'b0;
            case (alu_op)
                3'd0: r = ac & dr;
                3'd1: {cy, r} = {1'b0, ac} + {1'b0, dr};
                3'd2: r = dr;
                3'd3: r = ~ac;
                3'd4: r = {e, ac[15:1]};
                3'd5: r = {ac[14:0], e};
                default: r = ac + 16'h1;
            endcase
            n_ar = ar_clr ? 12'h0 : ar_write ? b[11:0] : ar_inc ? ar + 12'h1 : ar;
            n_pc = pc_clr ? 12'h0 : pc_write ? b[11:0] : pc_inc ? pc + 12'h1 : pc;
            n_dr = dr_clr ? 16'h0 : dr_write ? b : dr_inc ? dr + 16'h1 : dr;
            n_ac = ac_clr ? 16'h0 : ac_write ? r : ac_inc ? ac + 16'h1 : ac;
            n_ir = ir_clr ? 16'h0 : ir_write ? b : ir_inc ? ir_q + 16'h1 : ir_q;
            n_tr = tr_clr ? 16'h0 : tr_write ? b : tr_inc ? tr + 16'h1 : tr;
            n_e = e_clr ? 1'b0 : e_cmp ? ~e : (ac_write && alu_op == 3'd1) ? cy :
                  (ac_write && alu_op == 3'd4) ? ac[0] : (ac_write && alu_op == 3'd5) ? ac[15] : e;
            we = mem_write; wa = ar; wd = b;
            @(posedge clk);
            #1;
            ar = n_ar; pc = n_pc; dr = n_dr; ac = n_ac; ir_q = n_ir; tr = n_tr; e = n_e;
            if (we) mem[wa] = wd;
        end
        #1;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0;
        ar = 12'h0; pc = 12'h0; dr = 16'h0; ac = 16'h0; ir_q = 16'h0; tr = 16'h0; e = 1'b0;
        tick(2);
        chk("reset_sc", 16'(sc), 16'h0);
        chk("reset_halted", 16'(halted), 16'h0);
        chk("reset_strobes", 16'(any_strobe), 16'h0);
        reset = 1'b0;
        #1;
        chk("t0_bus", 16'(bus_sel), 16'h2);
        chk("t0_ar_write", 16'(ar_write), 16'h1);

        // LDA direct
        pc = 12'h010; mem[12'h010] = 16'h2020; mem[12'h020] = 16'h1234;
        tick(6);
        chk("lda_ac", ac, 16'h1234);
        chk("lda_pc", 16'(pc), 16'h011);
        chk("lda_sc", 16'(sc), 16'h0);

        // ADD indirect with carry out
        pc = 12'h010; mem[12'h010] = 16'h9030; mem[12'h030] = 16'h0040; mem[12'h040] = 16'h0005;
        ac = 16'hFFFF; e = 1'b0;
        tick(6);
        chk("addi_ac", ac, 16'h0004);
        chk("addi_e", 16'(e), 16'h1);
        chk("addi_sc", 16'(sc), 16'h0);

        // ISZ wrapping to zero skips
        pc = 12'h010; mem[12'h010] = 16'h6050; mem[12'h050] = 16'hFFFF;
        tick(6);
        chk("isz_sc_t6", 16'(sc), 16'h6);
        tick(1);
        chk("isz_mem", mem[12'h050], 16'h0000);
        chk("isz_pc", 16'(pc), 16'h012);
        chk("isz_sc", 16'(sc), 16'h0);

        // ISZ non-zero result does not skip
        pc = 12'h010; mem[12'h050] = 16'h0005;
        tick(7);
        chk("isz_nz_mem", mem[12'h050], 16'h0006);
        chk("isz_nz_pc", 16'(pc), 16'h011);

        // BSA
        pc = 12'h100; mem[12'h100] = 16'h5060;
        tick(6);
        chk("bsa_mem", mem[12'h060], 16'h0101);
        chk("bsa_pc", 16'(pc), 16'h061);
        chk("bsa_sc", 16'(sc), 16'h0);

        // SZA with AC=0 skips, AC!=0 does not
        pc = 12'h010; mem[12'h010] = 16'h7004; ac = 16'h0000;
        tick(4);
        chk("sza_skip_pc", 16'(pc), 16'h012);
        chk("sza_sc", 16'(sc), 16'h0);
        pc = 12'h010; ac = 16'h0005;
        tick(4);
        chk("sza_noskip_pc", 16'(pc), 16'h011);

        // CLA|CMA together: only CLA acts
        pc = 12'h010; mem[12'h010] = 16'h7A00; ac = 16'h1234;
        tick(4);
        chk("cla_prio_ac", ac, 16'h0000);
        // CMA alone
        pc = 12'h010; mem[12'h010] = 16'h7200; ac = 16'h00FF;
        tick(4);
        chk("cma_ac", ac, 16'hFF00);
        // CME
        pc = 12'h010; mem[12'h010] = 16'h7100; e = 1'b0;
        tick(4);
        chk("cme_e", 16'(e), 16'h1);

        // BUN: 5 cycles
        pc = 12'h010; mem[12'h010] = 16'h4123;
        tick(5);
        chk("bun_pc", 16'(pc), 16'h123);
        chk("bun_sc", 16'(sc), 16'h0);

        // HLT then 10 idle cycles
        pc = 12'h010; mem[12'h010] = 16'h7001;
        tick(4);
        chk("hlt_halted", 16'(halted), 16'h1);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("hlt_no_strobe", 16'(any_strobe), 16'h0);
        end
        chk("hlt_pc_frozen", 16'(pc), 16'h011);
        chk("hlt_sc_frozen", 16'(sc), 16'h0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        #1;
        chk("hlt_reset_clears", 16'(halted), 16'h0);

        // Reset in T4 of an ADD
        pc = 12'h010; mem[12'h010] = 16'h1070; mem[12'h070] = 16'h0003; ac = 16'h0010;
        tick(4);
        chk("mid_sc_t4", 16'(sc), 16'h4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        #1;
        chk("mid_sc", 16'(sc), 16'h0);
        chk("mid_bus", 16'(bus_sel), 16'h2);
        chk("mid_ac", ac, 16'h0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
